// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity modes and
// oversampling constants used by the transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_e;

   localparam int PAR_NONE   = 0;
   localparam int PAR_EVEN   = 1;
   localparam int PAR_ODD    = 2;
   localparam int OVERSAMPLE = 16;

   // Tick counter must reach both OVERSAMPLE-1 and SB_TICK-1.
   function automatic int tick_width(input int sb);
      return ($clog2(sb) > 4) ? $clog2(sb) : 4;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DVSR clocks.
// clr restarts the period so a frame starts on a full tick boundary.
module uart_baud_gen #(
   parameter int DVSR = 54
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DVSR - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == C_LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit stage: pulls bytes from the TX FIFO and serializes
// start, LSB-first data, optional parity and stop onto a registered tx.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DVSR       = 54,
   parameter int SB_TICK    = 16,
   parameter int PARITY     = PAR_NONE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done_tick
);

   localparam int SW = tick_width(SB_TICK);
   localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STP  = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);
   localparam logic PAR_INV = (PARITY == PAR_ODD);
   localparam logic PAR_ON  = (PARITY != PAR_NONE);

   tx_state_e             r_state, w_state_nxt;
   logic [SW-1:0]         r_s, w_s_nxt;
   logic [NW-1:0]         r_n, w_n_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
   logic                  r_par, w_par_nxt;
   logic                  r_tx, w_tx_nxt;
   logic                  w_tick;
   logic                  w_clr;

   // Restart the baud period in FETCH so START gets full-length ticks.
   assign w_clr = (r_state == S_FETCH);

   uart_baud_gen #(
      .DVSR (DVSR)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_n     <= w_n_nxt;
         r_shift <= w_shift_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_s_nxt      = r_s;
      w_n_nxt      = r_n;
      w_shift_nxt  = r_shift;
      w_par_nxt    = r_par;
      fifo_rd      = 1'b0;
      tx_done_tick = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd     = !reset;
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            w_shift_nxt = fifo_data;
            w_par_nxt   = (^fifo_data) ^ PAR_INV;
            w_s_nxt     = '0;
            w_state_nxt = S_START;
         end
         S_START: begin
            if (w_tick) begin
               if (r_s == S_BIT) begin
                  w_s_nxt     = '0;
                  w_n_nxt     = '0;
                  w_state_nxt = S_DATA;
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_s == S_BIT) begin
                  w_s_nxt     = '0;
                  w_shift_nxt = r_shift >> 1;
                  if (r_n == N_LAST) begin
                     w_state_nxt = PAR_ON ? S_PARITY : S_STOP;
                  end else begin
                     w_n_nxt = r_n + NW'(1);
                  end
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               if (r_s == S_BIT) begin
                  w_s_nxt     = '0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (r_s == S_STP) begin
                  w_s_nxt      = '0;
                  w_state_nxt  = S_IDLE;
                  tx_done_tick = !reset;
               end else begin
                  w_s_nxt = r_s + SW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Line level follows the state being entered, so tx lines up with it.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[0];
         S_PARITY: w_tx_nxt = w_par_nxt;
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   assign tx      = r_tx;
   assign tx_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four parameter variants fed by FIFO models,
// checked against per-cycle waveforms built from frame-level rules.
module tb_uart_tx_engine;

   localparam int NI   = 4;
   localparam int DV   = 4;
   localparam int BITC = 16 * DV;
   localparam int MAXC = 8192;
   localparam int PAR_A [NI] = '{0, 1, 2, 0};
   localparam int SB_A  [NI] = '{16, 16, 16, 32};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NI-1:0] f_empty, f_rd, tx, busy, done;
   logic [7:0]    mem  [NI][64];
   int            wr_p [NI];
   logic [7:0]    sent [NI][16];
   int            n_sent [NI];

   int checks   = 0;
   int failures = 0;

   logic tx_h [NI][MAXC];
   logic rd_h [NI][MAXC];
   logic bs_h [NI][MAXC];
   logic dn_h [NI][MAXC];
   logic e_tx [NI][MAXC];
   logic e_rd [NI][MAXC];
   logic e_bs [NI][MAXC];
   logic e_dn [NI][MAXC];

   for (genvar g = 0; g < NI; g++) begin : g_u
      int         rd_p = 0;
      logic [7:0] q    = '0;

      always @(posedge clk) begin
         if (f_rd[g]) begin
            q    <= mem[g][rd_p % 64];
            rd_p <= rd_p + 1;
         end
      end

      assign f_empty[g] = (rd_p == wr_p[g]);

      uart_tx_engine #(
         .DATA_WIDTH (8),
         .DVSR       (DV),
         .SB_TICK    (SB_A[g]),
         .PARITY     (PAR_A[g])
      ) u_dut (
         .clk          (clk),
         .reset        (rst),
         .fifo_empty   (f_empty[g]),
         .fifo_data    (q),
         .fifo_rd      (f_rd[g]),
         .tx           (tx[g]),
         .tx_busy      (busy[g]),
         .tx_done_tick (done[g])
      );
   end

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         for (int g = 0; g < NI; g++) begin
            tx_h[g][cyc] <= tx[g];
            rd_h[g][cyc] <= f_rd[g];
            bs_h[g][cyc] <= busy[g];
            dn_h[g][cyc] <= done[g];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int flen(input int g);
      return DV * (16 * (9 + ((PAR_A[g] != 0) ? 1 : 0)) + SB_A[g]);
   endfunction

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int g, input logic [7:0] b);
      mem[g][wr_p[g] % 64] = b;
      sent[g][n_sent[g]]   = b;
      n_sent[g]++;
      wr_p[g]++;
   endtask

   task automatic clear_exp(input int a, input int b);
      for (int g = 0; g < NI; g++) begin
         for (int t = a; t < b; t++) begin
            e_tx[g][t] = 1'b1;
            e_rd[g][t] = 1'b0;
            e_bs[g][t] = 1'b0;
            e_dn[g][t] = 1'b0;
         end
      end
   endtask

   // Frame as (level, length) segments; abort >= 0 truncates after that cycle.
   task automatic add_frame(input int g, input int s, input logic [7:0] b,
                            input int abort);
      int lev [$];
      int len [$];
      int t;
      int e;
      lev.push_back(0);
      len.push_back(BITC);
      for (int i = 0; i < 8; i++) begin
         lev.push_back(b[i] ? 1 : 0);
         len.push_back(BITC);
      end
      if (PAR_A[g] == 1) begin
         lev.push_back((^b) ? 1 : 0);
         len.push_back(BITC);
      end else if (PAR_A[g] == 2) begin
         lev.push_back((^b) ? 0 : 1);
         len.push_back(BITC);
      end
      lev.push_back(1);
      len.push_back(DV * SB_A[g]);
      t = s;
      foreach (lev[k]) begin
         for (int j = 0; j < len[k]; j++) begin
            if (abort < 0 || t <= abort) e_tx[g][t] = (lev[k] != 0);
            t++;
         end
      end
      e = t - 1;
      e_rd[g][s - 2] = 1'b1;
      for (int c = s - 1; c <= e; c++) begin
         if (abort < 0 || c <= abort) e_bs[g][c] = 1'b1;
      end
      if (abort < 0) e_dn[g][e] = 1'b1;
   endtask

   task automatic cmp_window(input string tag, input int w0, input int w1);
      for (int g = 0; g < NI; g++) begin
         int m_tx, m_rd, m_bs, m_dn, n_rd, x_rd;
         m_tx = 0; m_rd = 0; m_bs = 0; m_dn = 0; n_rd = 0; x_rd = 0;
         for (int t = w0; t < w1; t++) begin
            if (tx_h[g][t] !== e_tx[g][t]) m_tx++;
            if (rd_h[g][t] !== e_rd[g][t]) m_rd++;
            if (bs_h[g][t] !== e_bs[g][t]) m_bs++;
            if (dn_h[g][t] !== e_dn[g][t]) m_dn++;
            if (rd_h[g][t] === 1'b1) n_rd++;
            if (e_rd[g][t] === 1'b1) x_rd++;
         end
         check($sformatf("%s_u%0d_tx_bad_cycles", tag, g), m_tx, 0);
         check($sformatf("%s_u%0d_rd_bad_cycles", tag, g), m_rd, 0);
         check($sformatf("%s_u%0d_busy_bad_cycles", tag, g), m_bs, 0);
         check($sformatf("%s_u%0d_done_bad_cycles", tag, g), m_dn, 0);
         check($sformatf("%s_u%0d_rd_pulses", tag, g), n_rd, x_rd);
      end
   endtask

   // Line-level receiver: find start edges, sample mid-bit.
   task automatic decode(input string tag, input int w0, input int w1);
      for (int g = 0; g < NI; g++) begin
         int t, nf, p, fl;
         logic [7:0] b;
         logic eb;
         p  = (PAR_A[g] != 0) ? 1 : 0;
         fl = flen(g);
         nf = 0;
         t  = w0 + 1;
         while (t + fl < w1) begin
            if (tx_h[g][t-1] === 1'b1 && tx_h[g][t] === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  b[i] = tx_h[g][t + BITC/2 + BITC*(i+1)];
               end
               if (nf < n_sent[g]) begin
                  check($sformatf("%s_u%0d_byte%0d", tag, g, nf),
                        32'(b), 32'(sent[g][nf]));
                  if (p == 1) begin
                     eb = (^sent[g][nf]) ^ (PAR_A[g] == 2);
                     check($sformatf("%s_u%0d_par%0d", tag, g, nf),
                           32'(tx_h[g][t + BITC/2 + BITC*9]), 32'(eb));
                  end
               end
               check($sformatf("%s_u%0d_stop%0d", tag, g, nf),
                     32'(tx_h[g][t + BITC*(9+p) + DV*SB_A[g]/2]), 1);
               nf++;
               t += fl;
            end else begin
               t++;
            end
         end
         check($sformatf("%s_u%0d_frames", tag, g), nf, n_sent[g]);
      end
   endtask

   initial begin
      int k0, k1, k2, w1, s0, r0, fd, fs;
      logic [7:0] rb;
      for (int g = 0; g < NI; g++) begin
         wr_p[g]   = 0;
         n_sent[g] = 0;
      end

      // reset, then idle with an empty FIFO
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
         check($sformatf("rst_u%0d_tx", g), 32'(tx[g]), 1);
         check($sformatf("rst_u%0d_busy", g), 32'(busy[g]), 0);
         check($sformatf("rst_u%0d_rd", g), 32'(f_rd[g]), 0);
         check($sformatf("rst_u%0d_done", g), 32'(done[g]), 0);
      end
      k0 = cyc;
      clear_exp(k0, k0 + 1000);
      wait_until(k0 + 1000);
      cmp_window("idle", k0, k0 + 1000);

      // directed plus random bytes on every variant
      k0 = cyc;
      clear_exp(k0, MAXC);
      push(0, 8'h55);
      add_frame(0, k0 + 2, 8'h55, -1);
      for (int j = 0; j < 3; j++) begin
         rb = (j == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
         push(1, rb);
         add_frame(1, k0 + 2 + j * (flen(1) + 2), rb, -1);
      end
      for (int j = 0; j < 2; j++) begin
         rb = (j == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
         push(2, rb);
         add_frame(2, k0 + 2 + j * (flen(2) + 2), rb, -1);
      end
      for (int j = 0; j < 3; j++) begin
         rb = 8'($urandom_range(0, 255));
         push(3, rb);
         add_frame(3, k0 + 2 + j * (flen(3) + 2), rb, -1);
      end
      k1 = k0 + flen(0) + 60;
      wait_until(k1);
      for (int j = 0; j < 3; j++) begin
         rb = (j == 0) ? 8'h01 : ((j == 1) ? 8'hFF : 8'h80);
         push(0, rb);
         add_frame(0, k1 + 2 + j * (flen(0) + 2), rb, -1);
      end
      w1 = k1 + 2 + 3 * (flen(0) + 2) + 20;
      wait_until(w1);
      cmp_window("frames", k0, w1);
      decode("frames", k0, w1);

      fd = -1;
      for (int t = k0; t < w1; t++) begin
         if (fd < 0 && dn_h[3][t] === 1'b1) fd = t;
      end
      check("stop32_done_cycle", fd, k0 + 2 + flen(3) - 1);
      if (fd >= 0) begin
         check("stop32_gap_high",
               32'(tx_h[3][fd+1] === 1'b1 && tx_h[3][fd+2] === 1'b1), 1);
         check("stop32_next_start", 32'(tx_h[3][fd+3]), 0);
      end

      // reset during data bit 3, then a fresh frame from the FIFO
      for (int g = 0; g < NI; g++) n_sent[g] = 0;
      k2 = cyc;
      clear_exp(k2, MAXC);
      push(0, 8'hC3);
      push(0, 8'h3C);
      s0 = k2 + 2;
      r0 = s0 + 4 * BITC + 20;
      add_frame(0, s0, 8'hC3, r0);
      add_frame(0, r0 + 3, 8'h3C, -1);
      wait_until(r0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_tx_high", 32'(tx[0]), 1);
      check("abort_idle", 32'(busy[0]), 0);
      check("abort_no_rd_in_reset", 32'(f_rd[0]), 0);
      rst = 1'b0;
      #1;
      check("restart_rd", 32'(f_rd[0]), 1);
      w1 = r0 + 3 + flen(0) + 20;
      wait_until(w1);
      cmp_window("abort", k2, w1);
      fs = -1;
      for (int t = r0 + 1; t < w1; t++) begin
         if (fs < 0 && tx_h[0][t] === 1'b0) fs = t;
      end
      check("restart_start_cycle", fs, r0 + 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
